// File: rtl/izh_neuron_array.sv
// rtl/izh_neuron_array.sv - N Izhikevich neurons time-multiplexed onto one fixed-point update datapath
// Define IZH_SPIKE_COUNT_EN to add per-neuron saturating spike counters and the spike_cnt probe.
module izh_neuron_array #(
   parameter int N           = 4,
   parameter int V_WIDTH     = 20,
   parameter int FR_WIDTH    = 11,
   parameter int DT_SHIFT    = 2,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [2*N-1:0]            mode,
   input  logic [N*V_WIDTH-1:0]      synin,
   input  logic [$clog2(N)-1:0]      probe_sel,
   output logic                      busy,
   output logic                      done,
   output logic [N-1:0]              spikes,
   output logic signed [V_WIDTH-1:0] vout,
   output logic signed [V_WIDTH-1:0] uout
`ifdef IZH_SPIKE_COUNT_EN
   ,
   output logic [COUNT_WIDTH-1:0]    spike_cnt
`endif
);

   localparam int IW   = $clog2(N);
   localparam int W    = 2*V_WIDTH + 4;
   localparam int ONE  = 1 << FR_WIDTH;
   localparam int K_I  = $rtoi(0.04 * ONE + 0.5);
   localparam int AS_I = $rtoi(0.02 * ONE + 0.5);
   localparam int AF_I = $rtoi(0.1 * ONE + 0.5);
   localparam int B_I  = $rtoi(0.2 * ONE + 0.5);

   localparam logic signed [W-1:0] KC   = W'(K_I);
   localparam logic signed [W-1:0] AS   = W'(AS_I);
   localparam logic signed [W-1:0] AF   = W'(AF_I);
   localparam logic signed [W-1:0] BC   = W'(B_I);
   localparam logic signed [W-1:0] FIVE = W'(5);
   localparam logic signed [W-1:0] OFS  = W'(140 * ONE);
   localparam logic signed [W-1:0] THR  = W'(30 * ONE);
   localparam logic signed [W-1:0] D_RS = W'(8 * ONE);
   localparam logic signed [W-1:0] D_IB = W'(4 * ONE);
   localparam logic signed [W-1:0] D_LO = W'(2 * ONE);
   localparam logic signed [V_WIDTH-1:0] C_RS  = V_WIDTH'(-65 * ONE);
   localparam logic signed [V_WIDTH-1:0] C_IB  = V_WIDTH'(-55 * ONE);
   localparam logic signed [V_WIDTH-1:0] C_CH  = V_WIDTH'(-50 * ONE);
   localparam logic signed [V_WIDTH-1:0] V_RST = V_WIDTH'(-65 * ONE);
   localparam logic signed [V_WIDTH-1:0] U_RST = V_WIDTH'((B_I * (-65 * ONE)) >>> FR_WIDTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                    state;
   logic [IW-1:0]             idx;
   logic [N-1:0]              shadow;
   logic signed [V_WIDTH-1:0] v [N];
   logic signed [V_WIDTH-1:0] u [N];

   logic [1:0]                m;
   logic signed [W-1:0]       vx, ux, ix, a, d, vv, dv, vn, bv, du, un;
   logic signed [V_WIDTH-1:0] c, v_next, u_next;
   logic                      spike;
   logic [N-1:0]              shadow_next;

   // Datapath always evaluates neuron idx; results are only committed in RUN.
   always_comb begin
      m  = mode[2*idx +: 2];
      vx = W'(v[idx]);
      ux = W'(u[idx]);
      ix = W'($signed(synin[idx*V_WIDTH +: V_WIDTH]));
      case (m)
         2'b00:   begin c = C_RS; d = D_RS; end
         2'b01:   begin c = C_IB; d = D_IB; end
         2'b10:   begin c = C_CH; d = D_LO; end
         default: begin c = C_RS; d = D_LO; end
      endcase
      a  = (m == 2'b11) ? AF : AS;
      vv = (vx * vx) >>> FR_WIDTH;
      dv = ((vv * KC) >>> FR_WIDTH) + FIVE * vx + OFS - ux + ix;
      vn = vx + (dv >>> DT_SHIFT);
      bv = (BC * vx) >>> FR_WIDTH;
      du = (a * (bv - ux)) >>> FR_WIDTH;
      un = ux + (du >>> DT_SHIFT);
      spike  = (vn >= THR);
      v_next = spike ? c : V_WIDTH'(vn);
      u_next = V_WIDTH'(spike ? un + d : un);
      shadow_next      = shadow;
      shadow_next[idx] = shadow[idx] | spike;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         idx    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         spikes <= '0;
         shadow <= '0;
         vout   <= V_RST;
         uout   <= U_RST;
         for (int i = 0; i < N; i++) begin
            v[i] <= V_RST;
            u[i] <= U_RST;
         end
      end else begin
         done <= 1'b0;
         vout <= v[probe_sel];
         uout <= u[probe_sel];
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= RUN;
                  idx    <= '0;
                  busy   <= 1'b1;
                  shadow <= '0;
               end
            end
            RUN: begin
               v[idx] <= v_next;
               u[idx] <= u_next;
               shadow <= shadow_next;
               if (idx == IW'(N-1)) begin
                  state  <= IDLE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  spikes <= shadow_next;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef IZH_SPIKE_COUNT_EN
   logic [COUNT_WIDTH-1:0] cnt [N];

   always_ff @(posedge clk) begin
      if (reset) begin
         spike_cnt <= '0;
         for (int i = 0; i < N; i++) cnt[i] <= '0;
      end else begin
         spike_cnt <= cnt[probe_sel];
         if (state == RUN && spike && cnt[idx] != '1)
            cnt[idx] <= cnt[idx] + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_izh_neuron_array.sv
// tb/tb_izh_neuron_array.sv - scoreboard bench for izh_neuron_array (default and DT_SHIFT=0 instances)
// Connects spike_cnt when IZH_SPIKE_COUNT_EN is defined.
module tb_izh_neuron_array;

   localparam int N  = 4;
   localparam int VW = 20;
   localparam int FR = 11;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset, start, start0;
   logic [2*N-1:0]    mode, mode0;
   logic [N*VW-1:0]   synin, synin0;
   logic [1:0]        probe_sel, probe_sel0;
   logic              busy, done, busy0, done0;
   logic [N-1:0]      spikes, spikes0;
   logic signed [VW-1:0] vout, uout, vout0, uout0;
`ifdef IZH_SPIKE_COUNT_EN
   logic [7:0]        spike_cnt, spike_cnt0;
`endif

   izh_neuron_array #(.N(N), .V_WIDTH(VW), .FR_WIDTH(FR), .DT_SHIFT(2), .COUNT_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .synin(synin),
      .probe_sel(probe_sel), .busy(busy), .done(done), .spikes(spikes),
      .vout(vout), .uout(uout)
`ifdef IZH_SPIKE_COUNT_EN
      , .spike_cnt(spike_cnt)
`endif
   );

   izh_neuron_array #(.N(N), .V_WIDTH(VW), .FR_WIDTH(FR), .DT_SHIFT(0), .COUNT_WIDTH(8)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .mode(mode0), .synin(synin0),
      .probe_sel(probe_sel0), .busy(busy0), .done(done0), .spikes(spikes0),
      .vout(vout0), .uout(uout0)
`ifdef IZH_SPIKE_COUNT_EN
      , .spike_cnt(spike_cnt0)
`endif
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int errors  = 0;
   int sp_cnt [N];

   typedef struct {
      int           at;
      logic [N-1:0] sp;
      logic [N-1:0] mask;
   } exp_t;

   exp_t q[$];
   exp_t q0[$];

   task automatic check(input string name, input longint act, input longint exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
      vectors++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Monitors: every done pops the oldest expected sweep and checks its edge and spikes.
   always @(negedge clk) begin : mon
      exp_t e;
      if (done === 1'b1) begin
         for (int i = 0; i < N; i++) if (spikes[i]) sp_cnt[i]++;
         if (q.size() == 0) begin
            vectors++; errors++;
            $display("FAIL unexpected_done: done at edge %0d, required no done", cyc);
         end else begin
            e = q.pop_front();
            check("done_edge", cyc, e.at);
            if (e.mask != '0) check("spikes", longint'(spikes & e.mask), longint'(e.sp));
         end
      end
   end

   always @(negedge clk) begin : mon0
      exp_t e;
      if (done0 === 1'b1) begin
         if (q0.size() == 0) begin
            vectors++; errors++;
            $display("FAIL unexpected_done0: done at edge %0d, required no done", cyc);
         end else begin
            e = q0.pop_front();
            check("done0_edge", cyc, e.at);
            if (e.mask != '0) check("spikes0", longint'(spikes0 & e.mask), longint'(e.sp));
         end
      end
   end

   task automatic sweep(input logic [N-1:0] sp, input logic [N-1:0] mask);
      int k;
      start = 1'b1;
      q.push_back('{at: cyc + 1 + N, sp: sp, mask: mask});
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (done !== 1'b1 && k < 4*N) begin
         @(negedge clk);
         k++;
      end
      if (done !== 1'b1) begin
         vectors++; errors++;
         $display("FAIL sweep_timeout: done=%b after %0d cycles, required 1", done, k);
      end
   endtask

   task automatic probe(input int sel, output logic signed [VW-1:0] pv, output logic signed [VW-1:0] pu);
      probe_sel = 2'(sel);
      @(negedge clk);
      pv = vout;
      pu = uout;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      logic signed [VW-1:0] pv, pu;
      int t0, k;
      longint vmin, vmax;

      reset = 1'b1; start = 1'b0; start0 = 1'b0;
      mode  = '0;   synin = '0;   probe_sel = '0;
      mode0 = 8'b00_11_00_00;
      synin0 = {20'sd0, 20'sd524287, 20'sd0, 20'sd0};
      probe_sel0 = 2'd2;
      for (int i = 0; i < N; i++) sp_cnt[i] = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      check("rst_vout", vout, -133120);
      check("rst_uout", uout, -26650);
      check("rst_spikes", spikes, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);

      // DT_SHIFT=0 instance: FS neuron 2 with maximal input spikes on the first step.
      start0 = 1'b1;
      q0.push_back('{at: cyc + 1 + N, sp: 4'b0100, mask: 4'b1111});
      @(negedge clk);
      start0 = 1'b0;
      k = 0;
      while (done0 !== 1'b1 && k < 4*N) begin
         @(negedge clk);
         k++;
      end
      check("dut0_done_seen", done0, 1);
      @(negedge clk);
      check("dut0_v2", vout0, -133120);
      check("dut0_u2", uout0, -22554);

      // Sweep timing with a second start mid-sweep that must be ignored.
      start = 1'b1;
      q.push_back('{at: cyc + 1 + N, sp: 4'b0000, mask: 4'b1111});
      t0 = cyc + 1;
      for (int j = 0; j <= N + 1; j++) begin
         @(negedge clk);
         start = (j == 1);
         check("busy_timing", busy, longint'(j < N));
         check("done_timing", done, longint'(j == N));
      end
      check("sweep_edge_base", cyc, t0 + N + 1);

      // All RS, no input: never spikes and v stays near rest.
      vmin = 0; vmax = -1000000;
      vmin = 1000000;
      for (int s = 0; s < 200; s++) begin
         sweep(4'b0000, 4'b1111);
         for (int i = 0; i < N; i++) begin
            probe(i, pv, pu);
            if (pv < vmin) vmin = pv;
            if (pv > vmax) vmax = pv;
         end
      end
      check_range("rs_vmin", vmin, -75 * 2048, -55 * 2048);
      check_range("rs_vmax", vmax, -75 * 2048, -55 * 2048);

      // Reset while neuron 2 is being updated aborts the sweep.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (N + 2) @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_spikes", spikes, 0);
      for (int i = 0; i < N; i++) begin
         probe(i, pv, pu);
         check("abort_v", pv, -133120);
         check("abort_u", pu, -26650);
      end
      sweep(4'b0000, 4'b1111);

      // Constant drive: RS neuron 0 and FS neuron 1 both fire, FS faster.
      mode  = 8'b00_00_11_00;
      synin = {4{20'sd20480}};
      for (int i = 0; i < N; i++) sp_cnt[i] = 0;
      for (int s = 0; s < 1000; s++) sweep(4'b0000, 4'b0000);
      check_range("rs_spiked", sp_cnt[0], 1, 1 << 30);
      check_range("fs_gt_rs", sp_cnt[1], sp_cnt[0] + 1, 1 << 30);
`ifdef IZH_SPIKE_COUNT_EN
      probe(0, pv, pu);
      check("cnt_rs", spike_cnt, sp_cnt[0] > 255 ? 255 : sp_cnt[0]);
      probe(1, pv, pu);
      check("cnt_fs", spike_cnt, sp_cnt[1] > 255 ? 255 : sp_cnt[1]);
`endif

      repeat (2*N) @(negedge clk);
      check("pending_sweeps", q.size() + q0.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
